// File: rtl/romulus_tbc_sequencer.sv
// -----------------------------------------------------------------------------
// romulus_tbc_sequencer
//
// Round sequencer for one Skinny-128-384+ TBC call in the Romulus datapath.
// A call is IDLE -> RUN (ROUNDS/UNROLL cycles) -> CORR (one tweakey-correction
// cycle) -> DONE (one-cycle done pulse). From DONE a fresh start chains
// directly into the next call with no IDLE gap. All outputs are Moore, decoded
// from registered state.
//
// Parameters
//   ROUNDS  TBC rounds per call (must be a multiple of UNROLL)
//   UNROLL  rounds evaluated per clock (1 or 2)
//   CONSTW  width of the round-constant output (>= 12 when UNROLL = 2)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request a call; honoured only in IDLE or DONE
//   keep_cnt          sampled with an accepted start: 1 = advance counter,
//                     0 = rewind it during the correction cycle
//   busy              high in RUN and CORR
//   done              one-cycle pulse when the call has completed
//   constant          round constant(s) for the current RUN cycle, 0 otherwise
//   sen/senc          state register enable / tbc select
//   xen/xenc          TK1 (key) register enable / tbc select
//   yen/yenc          TK2 (tweak) register enable / tbc select
//   zen/zenc          TK3 (counter) register enable / tbc select
//   correct_cnt       counter-correction source select (valid in CORR only)
// -----------------------------------------------------------------------------
module romulus_tbc_sequencer #(
  parameter int ROUNDS = 40,
  parameter int UNROLL = 1,
  parameter int CONSTW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              keep_cnt,
  output logic              busy,
  output logic              done,
  output logic [CONSTW-1:0] constant,
  output logic              sen,
  output logic              senc,
  output logic              xen,
  output logic              xenc,
  output logic              yen,
  output logic              yenc,
  output logic              zen,
  output logic              zenc,
  output logic              correct_cnt
);

  localparam int CYCLES = ROUNDS / UNROLL;
  localparam int CNTW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNTW-1:0] LAST_RND = CNTW'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        rc_q, rc_d;
  logic [CNTW-1:0]   rnd_q, rnd_d;
  logic              keep_q, keep_d;

  // One step of the 6-bit round-constant LFSR.
  function automatic logic [5:0] rc_step(input logic [5:0] v);
    return {v[4:0], ~(v[5] ^ v[4])};
  endfunction

  logic [5:0]        rc_1, rc_2;
  logic [CONSTW-1:0] run_const;

  assign rc_1 = rc_step(rc_q);
  assign rc_2 = rc_step(rc_1);

  // With two rounds per clock the earlier round sits in the low six bits.
  always_comb begin
    run_const = (UNROLL == 2) ? CONSTW'({rc_2, rc_1}) : CONSTW'(rc_1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= 6'h00;
      rnd_q   <= '0;
      keep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rnd_q   <= rnd_d;
      keep_q  <= keep_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    rnd_d   = rnd_q;
    keep_d  = keep_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          rc_d    = 6'h00;
          rnd_d   = '0;
          keep_d  = keep_cnt;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rc_d = (UNROLL == 2) ? rc_2 : rc_1;
        // Hold the counter on the last round so it never wraps within a call.
        if (rnd_q == LAST_RND) begin
          state_d = CORR;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      CORR:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    constant    = '0;
    sen         = 1'b0;
    senc        = 1'b0;
    xen         = 1'b0;
    xenc        = 1'b0;
    yen         = 1'b0;
    yenc        = 1'b0;
    zen         = 1'b0;
    zenc        = 1'b0;
    correct_cnt = 1'b0;
    unique case (state_q)
      RUN: begin
        busy     = 1'b1;
        constant = run_const;
        sen      = 1'b1;
        senc     = 1'b1;
        xen      = 1'b1;
        xenc     = 1'b1;
        yen      = 1'b1;
        yenc     = 1'b1;
        zen      = 1'b1;
        zenc     = 1'b1;
      end
      CORR: begin
        // Tweakey registers reload from the correction path, state holds.
        busy        = 1'b1;
        xen         = 1'b1;
        yen         = 1'b1;
        zen         = 1'b1;
        correct_cnt = keep_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_romulus_tbc_sequencer
//
// Drives two sequencers (40 rounds at UNROLL=1 and UNROLL=2) from shared
// start/keep_cnt inputs. A call-schedule reference model predicts, for each
// cycle, the output vector from the position inside the current call and the
// round number's LFSR value, plus directed checks of the documented
// constants, latencies and reset behaviour.
// -----------------------------------------------------------------------------
module tb_romulus_tbc_sequencer;

  localparam int ROUNDS = 40;

  logic clk      = 1'b0;
  logic clk_en   = 1'b0;
  logic rst_n    = 1'b1;
  logic start    = 1'b0;
  logic keep_cnt = 1'b0;

  logic        busy1, done1, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, cc1;
  logic        busy2, done2, sen2, senc2, xen2, xenc2, yen2, yenc2, zen2, zenc2, cc2;
  logic [11:0] const1, const2;

  romulus_tbc_sequencer #(.ROUNDS(ROUNDS), .UNROLL(1), .CONSTW(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .keep_cnt(keep_cnt),
    .busy(busy1), .done(done1), .constant(const1),
    .sen(sen1), .senc(senc1), .xen(xen1), .xenc(xenc1),
    .yen(yen1), .yenc(yenc1), .zen(zen1), .zenc(zenc1), .correct_cnt(cc1)
  );

  romulus_tbc_sequencer #(.ROUNDS(ROUNDS), .UNROLL(2), .CONSTW(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .keep_cnt(keep_cnt),
    .busy(busy2), .done(done2), .constant(const2),
    .sen(sen2), .senc(senc2), .xen(xen2), .xenc(xenc2),
    .yen(yen2), .yenc(yenc2), .zen(zen2), .zenc(zenc2), .correct_cnt(cc2)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position inside the current call per instance
  // (-1 = idle, 0..N-1 = RUN rounds, N = CORR, N+1 = DONE).
  int   pos    [2] = '{-1, -1};
  logic kp     [2] = '{1'b0, 1'b0};
  int   unroll [2] = '{1, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round constant for round n (1-based): n applications of the LFSR from 0.
  function automatic logic [5:0] round_rc(input int n);
    logic [5:0] v = 6'h00;
    for (int i = 0; i < n; i++) v = {v[4:0], ~(v[5] ^ v[4])};
    return v;
  endfunction

  // Packed vector {busy,done,sen,senc,xen,xenc,yen,yenc,zen,zenc,cc,constant}.
  function automatic logic [31:0] expect_vec(input int u, input int p, input logic k);
    int n = ROUNDS / u;
    logic [11:0] c;
    if (p < 0) return 32'h0;
    if (p < n) begin
      c = (u == 1) ? {6'h00, round_rc(p + 1)} : {round_rc(2 * p + 2), round_rc(2 * p + 1)};
      return {9'h0, 1'b1, 1'b0, 8'hFF, 1'b0, c};
    end
    if (p == n) return {9'h0, 1'b1, 1'b0, 8'b0010_1010, k, 12'h000};
    return {9'h0, 1'b0, 1'b1, 8'h00, 1'b0, 12'h000};
  endfunction

  function automatic logic [31:0] obs1();
    return {9'h0, busy1, done1, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, cc1, const1};
  endfunction

  function automatic logic [31:0] obs2();
    return {9'h0, busy2, done2, sen2, senc2, xen2, xenc2, yen2, yenc2, zen2, zenc2, cc2, const2};
  endfunction

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, compare both instances at the next falling edge.
  task automatic cycle(input logic s, input logic k);
    start    = s;
    keep_cnt = k;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int n = ROUNDS / unroll[i];
      if (!rst_n) begin
        pos[i] = -1;
      end else if (s && (pos[i] < 0 || pos[i] == n + 1)) begin
        pos[i] = 0;
        kp[i]  = k;
      end else if (pos[i] >= 0) begin
        pos[i]++;
        if (pos[i] > n + 1) pos[i] = -1;
      end
    end
    @(negedge clk);
    check("u1_outputs", obs1(), expect_vec(1, pos[0], kp[0]));
    check("u2_outputs", obs2(), expect_vec(2, pos[1], kp[1]));
  endtask

  initial begin
    int d1, d2, busy_n, cc_n, done_n, gap_n;

    // Reset with the clock stopped: outputs clear immediately.
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_u1", obs1(), 32'h0);
    check("reset_async_u2", obs2(), 32'h0);
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    check("idle_busy", {31'h0, busy1}, 32'h0);

    // Single call: constant sequence, CORR decode, done latency.
    d1 = 0; d2 = 0; busy_n = 0;
    cycle(1'b1, 1'b0);
    if (busy1) busy_n++;
    check("u1_first_const", {20'h0, const1}, 32'h001);
    check("u2_first_const", {20'h0, const2}, 32'h0C1);
    for (int e = 2; e <= 50; e++) begin
      cycle(1'b0, 1'b0);
      if (busy1) busy_n++;
      if (done1 && d1 == 0) d1 = e;
      if (done2 && d2 == 0) d2 = e;
      if (e == 6)  check("u1_round6_const", {20'h0, const1}, 32'h03E);
      if (e == 20) check("u2_last_const", {20'h0, const2}, {20'h0, 6'h1A, 6'h2D});
      if (e == 40) check("u1_round40_const", {20'h0, const1}, 32'h01A);
      if (e == 41) check("u1_corr_sen_xen_xenc", {29'h0, sen1, xen1, xenc1}, 32'b010);
    end
    check("u1_done_latency", d1, 42);
    check("u2_done_latency", d2, 22);
    check("u1_busy_cycles", busy_n, 41);

    // keep_cnt latched at start, later toggles ignored.
    cc_n = 0;
    cycle(1'b1, 1'b1);
    for (int e = 2; e <= 45; e++) begin
      cycle(1'b0, (e < 20) ? 1'b0 : 1'b1);
      if (cc1) cc_n++;
    end
    check("u1_keep1_cc_cycles", cc_n, 1);
    cc_n = 0;
    cycle(1'b1, 1'b0);
    for (int e = 2; e <= 45; e++) begin
      cycle(1'b0, 1'b1);
      if (cc1) cc_n++;
    end
    check("u1_keep0_cc_cycles", cc_n, 0);

    // start held high: calls chain with no idle cycle between them.
    done_n = 0; gap_n = 0;
    for (int e = 1; e <= 126; e++) begin
      cycle(1'b1, e[0]);
      if (done1) done_n++;
      if (!busy1 && !done1) gap_n++;
    end
    check("u1_chain_done_pulses", done_n, 3);
    check("u1_chain_idle_gaps", gap_n, 0);
    for (int e = 0; e < 45; e++) cycle(1'b0, 1'b0);

    // start pulses during RUN/CORR are ignored by the busy instance.
    done_n = 0;
    cycle(1'b1, 1'b0);
    for (int e = 2; e <= 50; e++) begin
      cycle((e == 10 || e == 41) ? 1'b1 : 1'b0, 1'b1);
      if (done1) done_n++;
    end
    check("u1_ignored_start_dones", done_n, 1);

    // Reset on round 17 aborts the call.
    cycle(1'b1, 1'b1);
    for (int e = 2; e <= 17; e++) cycle(1'b0, 1'b0);
    check("u1_round17_const", {20'h0, const1}, {20'h0, 6'h00, round_rc(17)});
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_run_u1", obs1(), 32'h0);
    check("reset_mid_run_u2", obs2(), 32'h0);
    pos[0] = -1;
    pos[1] = -1;
    @(negedge clk);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    rst_n = 1'b1;
    done_n = 0;
    cycle(1'b1, 1'b0);
    for (int e = 2; e <= 45; e++) begin
      cycle(1'b0, 1'b0);
      if (done1) done_n++;
    end
    check("u1_after_reset_dones", done_n, 1);

    // Randomized start/keep traffic against the model.
    for (int e = 0; e < 400; e++) begin
      cycle(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
